// File: rtl/dpram_port_arbiter.sv
// Two-requester front end for the 8x32 dual-port RAM: serialises same-address
// write conflicts with rotating priority and returns read data one cycle later.
module dpram_port_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,

  output logic [ADDR_W-1:0] ADDR_A,
  output logic              WE_A,
  output logic [DATA_W-1:0] D_IN_A,
  input  logic [DATA_W-1:0] Q_OUT_A,

  output logic [ADDR_W-1:0] ADDR_B,
  output logic              WE_B,
  output logic [DATA_W-1:0] D_IN_B,
  input  logic [DATA_W-1:0] Q_OUT_B,

  output logic              prio,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic conflict;
  logic acc0;
  logic acc1;

  // Read/read to the same address is harmless; only a write makes it a collision.
  always_comb begin
    conflict = req0_valid & req1_valid & (req0_addr == req1_addr) & (req0_we | req1_we);
  end

  // Gating with rst_n keeps the RAM write enables low while reset is asserted.
  assign req0_ready = rst_n & (~conflict | ~prio);
  assign req1_ready = rst_n & (~conflict | prio);
  assign acc0       = req0_valid & req0_ready;
  assign acc1       = req1_valid & req1_ready;

  assign ADDR_A = req0_addr;
  assign D_IN_A = req0_wdata;
  assign WE_A   = acc0 & req0_we;
  assign ADDR_B = req1_addr;
  assign D_IN_B = req1_wdata;
  assign WE_B   = acc1 & req1_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      rsp0_valid <= acc0 & ~req0_we;
      rsp1_valid <= acc1 & ~req1_we;
    end
  end

  // Loser of a conflict wins the next one, bounding starvation to one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio         <= 1'b0;
      conflict_cnt <= '0;
    end else if (conflict) begin
      prio <= ~prio;
      if (conflict_cnt != {CNT_W{1'b1}}) begin
        conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
    end
  end

  // RAM output is already registered, so the data lines up with rsp_valid.
  assign rsp0_rdata = rsp0_valid ? Q_OUT_A : '0;
  assign rsp1_rdata = rsp1_valid ? Q_OUT_B : '0;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Bench for dpram_port_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of arbitration and RAM.
module tb_dpram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req0_we = 1'b0;
  logic [2:0]  req0_addr = '0;
  logic [31:0] req0_wdata = '0;
  logic        req1_valid = 1'b0, req1_we = 1'b0;
  logic [2:0]  req1_addr = '0;
  logic [31:0] req1_wdata = '0;

  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, prio;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic [2:0]  ADDR_A, ADDR_B;
  logic        WE_A, WE_B;
  logic [31:0] D_IN_A, D_IN_B, q_a, q_b;
  logic [15:0] conflict_cnt;

  logic        s_req0_ready, s_req1_ready, s_rsp0_valid, s_rsp1_valid, s_prio;
  logic [31:0] s_rsp0_rdata, s_rsp1_rdata, s_d_in_a, s_d_in_b;
  logic [2:0]  s_addr_a, s_addr_b;
  logic        s_we_a, s_we_b;
  logic [1:0]  s_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dpram_port_arbiter u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .ADDR_A(ADDR_A), .WE_A(WE_A), .D_IN_A(D_IN_A), .Q_OUT_A(q_a),
    .ADDR_B(ADDR_B), .WE_B(WE_B), .D_IN_B(D_IN_B), .Q_OUT_B(q_b),
    .prio(prio), .conflict_cnt(conflict_cnt)
  );

  // Narrow-counter instance sharing the same stimulus, to exercise saturation.
  dpram_port_arbiter #(.CNT_W(2)) u_dut_sat (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(s_rsp0_valid), .rsp0_rdata(s_rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(s_rsp1_valid), .rsp1_rdata(s_rsp1_rdata),
    .ADDR_A(s_addr_a), .WE_A(s_we_a), .D_IN_A(s_d_in_a), .Q_OUT_A(q_a),
    .ADDR_B(s_addr_b), .WE_B(s_we_b), .D_IN_B(s_d_in_b), .Q_OUT_B(q_b),
    .prio(s_prio), .conflict_cnt(s_cnt)
  );

  // The RAM itself: synchronous write, registered read.
  logic [31:0] ram [8] = '{default: 32'h0};
  always @(posedge clk) begin
    if (WE_A) ram[ADDR_A] <= D_IN_A;
    if (WE_B) ram[ADDR_B] <= D_IN_B;
    q_a <= ram[ADDR_A];
    q_b <= ram[ADDR_B];
  end

  // Reference model: who gets served, what memory holds, what each read returns.
  logic [31:0] m_mem [8] = '{default: 32'h0};
  logic        m_prio;
  int          m_cnt, m_cnt_sat;
  logic        m_rv0, m_rv1;
  logic [31:0] m_rd0, m_rd1;

  function automatic logic clash_now();
    return req0_valid && req1_valid && (req0_addr == req1_addr) && (req0_we || req1_we);
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic g0, g1;
    if (!rst_n) begin
      m_prio <= 1'b0; m_cnt <= 0; m_cnt_sat <= 0;
      m_rv0 <= 1'b0; m_rv1 <= 1'b0; m_rd0 <= '0; m_rd1 <= '0;
    end else begin
      if (clash_now()) begin
        g0 = (m_prio == 1'b0);
        g1 = (m_prio == 1'b1);
        m_prio    <= ~m_prio;
        m_cnt     <= (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
        m_cnt_sat <= (m_cnt_sat < 3) ? m_cnt_sat + 1 : m_cnt_sat;
      end else begin
        g0 = req0_valid;
        g1 = req1_valid;
      end
      m_rv0 <= g0 && !req0_we;
      m_rv1 <= g1 && !req1_we;
      m_rd0 <= m_mem[req0_addr];
      m_rd1 <= m_mem[req1_addr];
      if (g0 && req0_we) m_mem[req0_addr] <= req0_wdata;
      if (g1 && req1_we) m_mem[req1_addr] <= req1_wdata;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, on the falling edge.
  int wait0 = 0, wait1 = 0;
  always @(negedge clk) begin : compare
    logic r0, r1;
    r0 = rst_n && (!clash_now() || m_prio == 1'b0);
    r1 = rst_n && (!clash_now() || m_prio == 1'b1);
    chk("req0_ready", req0_ready, r0);
    chk("req1_ready", req1_ready, r1);
    chk("WE_A", WE_A, r0 && req0_valid && req0_we);
    chk("WE_B", WE_B, r1 && req1_valid && req1_we);
    chk("ADDR_A", ADDR_A, req0_addr);
    chk("ADDR_B", ADDR_B, req1_addr);
    chk("D_IN_A", D_IN_A, req0_wdata);
    chk("D_IN_B", D_IN_B, req1_wdata);
    chk("rsp0_valid", rsp0_valid, m_rv0);
    chk("rsp1_valid", rsp1_valid, m_rv1);
    chk("rsp0_rdata", rsp0_rdata, m_rv0 ? m_rd0 : 32'h0);
    chk("rsp1_rdata", rsp1_rdata, m_rv1 ? m_rd1 : 32'h0);
    chk("prio", prio, m_prio);
    chk("conflict_cnt", conflict_cnt, m_cnt);
    chk("conflict_cnt_sat", s_cnt, m_cnt_sat);
    wait0 = (rst_n && req0_valid && !req0_ready) ? wait0 + 1 : 0;
    wait1 = (rst_n && req1_valid && !req1_ready) ? wait1 + 1 : 0;
    chk("starve0", wait0 <= 1, 1'b1);
    chk("starve1", wait1 <= 1, 1'b1);
  end

  task automatic drive(input logic v0, input logic w0, input logic [2:0] a0, input logic [31:0] d0,
                       input logic v1, input logic w1, input logic [2:0] a1, input logic [31:0] d1);
    req0_valid = v0; req0_we = w0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = w1; req1_addr = a1; req1_wdata = d1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    logic a0, a1;
    @(negedge clk);
    chk("rst_ready0", req0_ready, 1'b0);
    chk("rst_prio", prio, 1'b0);
    chk("rst_cnt", conflict_cnt, 16'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Different-address writes proceed together.
    drive(1, 1, 3'd0, 32'h15, 1, 1, 3'd4, 32'h19);
    @(negedge clk);
    chk("t1_ready0", req0_ready, 1'b1);
    chk("t1_ready1", req1_ready, 1'b1);
    chk("t1_we", {WE_A, WE_B}, 2'b11);
    chk("t1_cnt", conflict_cnt, 16'd0);

    // Same-address write conflict: req0 first, then req1.
    next_cycle(); drive(1, 1, 3'd3, 32'h10, 1, 1, 3'd3, 32'h11);
    @(negedge clk);
    chk("t2_ready", {req0_ready, req1_ready}, 2'b10);
    next_cycle(); drive(0, 0, 3'd0, 32'h0, 1, 1, 3'd3, 32'h11);
    @(negedge clk);
    chk("t2_ready1", req1_ready, 1'b1);
    chk("t2_prio", prio, 1'b1);
    chk("t2_cnt", conflict_cnt, 16'd1);
    next_cycle(); drive(1, 0, 3'd3, 32'h0, 0, 0, 3'd0, 32'h0);
    next_cycle(); drive(0, 0, 3'd0, 32'h0, 0, 0, 3'd0, 32'h0);
    @(negedge clk);
    chk("t2_rsp0", {rsp0_valid, rsp0_rdata}, {1'b1, 32'h11});

    // Read/read same address is not a conflict.
    next_cycle(); drive(1, 0, 3'd3, 32'h0, 1, 0, 3'd3, 32'h0);
    @(negedge clk);
    chk("t3_ready", {req0_ready, req1_ready}, 2'b11);
    next_cycle(); drive(0, 0, 3'd0, 32'h0, 0, 0, 3'd0, 32'h0);
    @(negedge clk);
    chk("t3_rsp0", {rsp0_valid, rsp0_rdata}, {1'b1, 32'h11});
    chk("t3_rsp1", {rsp1_valid, rsp1_rdata}, {1'b1, 32'h11});
    chk("t3_cnt", conflict_cnt, 16'd1);

    // Persistent conflict on addr 5: prio starts at 1, so winners go 1,0,1,0.
    for (int k = 0; k < 4; k++) begin
      next_cycle(); drive(1, 1, 3'd5, 32'h50, 1, 1, 3'd5, 32'h51);
      @(negedge clk);
      chk("t4_ready", {req0_ready, req1_ready}, (k % 2 == 0) ? 2'b01 : 2'b10);
    end
    next_cycle(); drive(0, 0, 3'd0, 32'h0, 1, 0, 3'd5, 32'h0);
    @(negedge clk);
    chk("t4_cnt", conflict_cnt, 16'd5);
    chk("t5_cnt_sat", s_cnt, 2'd3);
    chk("t4_prio", prio, 1'b1);
    chk("t4_model_cnt", m_cnt, 5);
    next_cycle(); drive(0, 0, 3'd0, 32'h0, 0, 0, 3'd0, 32'h0);
    @(negedge clk);
    chk("t4_rsp1", {rsp1_valid, rsp1_rdata}, {1'b1, 32'h50});

    // Reset right after an accepted read; a pending write must not reach the RAM.
    next_cycle(); drive(1, 0, 3'd3, 32'h0, 0, 0, 3'd0, 32'h0);
    next_cycle(); drive(1, 1, 3'd6, 32'hDEAD, 0, 0, 3'd0, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("t6_rsp0", {rsp0_valid, rsp0_rdata}, 33'h0);
    chk("t6_prio", prio, 1'b0);
    chk("t6_cnt", conflict_cnt, 16'd0);
    chk("t6_we", {WE_A, req0_ready}, 2'b00);
    next_cycle(); drive(0, 0, 3'd0, 32'h0, 0, 0, 3'd0, 32'h0);
    rst_n = 1'b1;
    next_cycle(); drive(1, 0, 3'd6, 32'h0, 0, 0, 3'd0, 32'h0);
    next_cycle(); drive(0, 0, 3'd0, 32'h0, 0, 0, 3'd0, 32'h0);
    @(negedge clk);
    chk("t6_addr6", {rsp0_valid, rsp0_rdata}, {1'b1, 32'h0});

    // Randomized traffic; requests are held until accepted.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        drive(0, 0, 3'd0, 32'h0, 0, 0, 3'd0, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        continue;
      end
      if (!req0_valid || a0) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_we    = $urandom_range(0, 1) == 1;
        req0_addr  = 3'($urandom_range(0, (c % 5 == 0) ? 7 : 3));
        req0_wdata = $urandom;
      end
      if (!req1_valid || a1) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_we    = $urandom_range(0, 1) == 1;
        req1_addr  = 3'($urandom_range(0, (c % 7 == 0) ? 7 : 3));
        req1_wdata = $urandom;
      end
    end
    drive(0, 0, 3'd0, 32'h0, 0, 0, 3'd0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
